// File: rtl/spart_pkg.sv
// Shared constants and state type for the mini SPART serial path.
// The frame shape is common to the transmitter and receiver.
package spart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned SampleFirst = 7;
  localparam int unsigned SampleMid   = 8;
  localparam int unsigned SampleLast  = 9;
  localparam int unsigned DataBits    = 8;
  localparam int unsigned StopBits    = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop1,
    StStop2
  } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// ResetVal sets both flops so the output is defined straight out of reset.
module sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= ResetVal;
      q      <= ResetVal;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 8N2 framing, 16x oversampled, 2-of-3 vote at mid-bit.
// Delivers each byte with RDA and reports framing / overrun errors.
module spart_rx
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       Enable,
  input  logic       RxD,
  input  logic       clr_rda,
  output logic [7:0] RxD_data,
  output logic       RDA,
  output logic       framing_err,
  output logic       overrun_err
);

  localparam int unsigned ScntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW  = $clog2(DataBits);
  localparam logic [ScntW-1:0] ScntFirst = ScntW'(SampleFirst);
  localparam logic [ScntW-1:0] ScntMid   = ScntW'(SampleMid);
  localparam logic [ScntW-1:0] ScntLast  = ScntW'(SampleLast);
  localparam logic [ScntW-1:0] ScntWrap  = ScntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0]  IdxLast   = IdxW'(DataBits - 1);

  rx_state_e        state_q, state_d;
  logic [ScntW-1:0] scnt_q, scnt_d;
  logic [IdxW-1:0]  bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       samp_q, samp_d;
  logic             stop1_q, stop1_d;
  logic             rxSync, vote, decide, wrap, done;

  sync2 #(
    .ResetVal (1'b1)
  ) uSync (
    .clk (clk),
    .rst (rst),
    .d   (RxD),
    .q   (rxSync)
  );

  assign decide = Enable && (scnt_q == ScntLast);
  assign wrap   = Enable && (scnt_q == ScntWrap);
  // Votes from scnt 7 and 8 plus the live sample at scnt 9.
  assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxSync) | (samp_q[1] & rxSync);

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    samp_d   = samp_q;
    stop1_d  = stop1_q;
    done     = 1'b0;
    if (Enable) begin
      if (scnt_q == ScntFirst) samp_d[0] = rxSync;
      if (scnt_q == ScntMid)   samp_d[1] = rxSync;
      unique case (state_q)
        StIdle: begin
          // The detecting tick is scnt 0 of the start bit.
          if (!rxSync) begin
            state_d = StStart;
            scnt_d  = ScntW'(1);
          end
        end
        StStart: begin
          scnt_d = scnt_q + 1'b1;
          if (decide && vote) begin
            state_d = StIdle;
            scnt_d  = '0;
          end else if (wrap) begin
            state_d  = StData;
            bitIdx_d = '0;
          end
        end
        StData: begin
          scnt_d = scnt_q + 1'b1;
          if (decide) shift_d = {vote, shift_q[7:1]};
          if (wrap) begin
            bitIdx_d = bitIdx_q + 1'b1;
            if (bitIdx_q == IdxLast) state_d = StStop1;
          end
        end
        StStop1: begin
          scnt_d = scnt_q + 1'b1;
          if (decide) stop1_d = vote;
          if (wrap) state_d = StStop2;
        end
        StStop2: begin
          scnt_d = scnt_q + 1'b1;
          // Leave early so a back-to-back start edge is caught on time.
          if (decide) begin
            done    = 1'b1;
            state_d = StIdle;
            scnt_d  = '0;
          end
        end
        default: begin
          state_d = StIdle;
          scnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      scnt_q   <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      samp_q   <= '0;
      stop1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      samp_q   <= samp_d;
      stop1_q  <= stop1_d;
    end
  end

  // A clear landing on the completion cycle retires the old byte, so no overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RxD_data    <= 8'h00;
      RDA         <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else if (done) begin
      RxD_data    <= shift_q;
      RDA         <= 1'b1;
      framing_err <= ~stop1_q | ~vote;
      overrun_err <= ~clr_rda & (RDA | overrun_err);
    end else if (clr_rda) begin
      RDA         <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Scoreboard bench for spart_rx: a frame driver pushes expected bytes, a monitor
// pops and compares whenever the receiver presents a new byte.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Enable = 1'b0;
  logic       RxD = 1'b1;
  logic       clr_rda = 1'b0;
  logic [7:0] RxD_data;
  logic       RDA, framing_err, overrun_err;

  spart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .Enable      (Enable),
    .RxD         (RxD),
    .clr_rda     (clr_rda),
    .RxD_data    (RxD_data),
    .RDA         (RDA),
    .framing_err (framing_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       oe;
    int         tick;
  } exp_t;

  exp_t       sb[$];
  exp_t       got;
  int         nChecks = 0;
  int         nFails = 0;
  int         tickCount = 0;
  int         enMode = 0;
  int         div = 0;
  bit         modelRda = 1'b0;
  bit         modelOe = 1'b0;
  logic [7:0] lastByte = 8'h00;
  logic       prevRda = 1'b0, prevFe = 1'b0, prevOe = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic [7:0] rb;
  logic       rs1, rs2, doClr;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Baud ticks: every 4th clk in mode 0, random spacing in mode 1.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (enMode == 0) begin
        div    = (div + 1) % 4;
        Enable = (div == 0);
      end else begin
        Enable = ($urandom_range(0, 2) == 0);
      end
    end
  end

  always @(posedge clk) if (Enable) tickCount <= tickCount + 1;

  task automatic tick();
    do @(posedge clk); while (!Enable);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic s1, input logic s2,
                           input int noiseBit, input int rstBit, input bit push,
                           input bit chkTick, input bit clrAtDone);
    logic [10:0] bits;
    exp_t        e;
    bits = {s2, s1, b, 1'b0};
    tick();
    if (push) begin
      e.data = b;
      e.fe   = !(s1 && s2);
      e.oe   = clrAtDone ? 1'b0 : (modelRda | modelOe);
      // Detection happens one tick after the fall; the byte lands 169 ticks later.
      e.tick = chkTick ? tickCount + 170 : -1;
      sb.push_back(e);
      modelRda = 1'b1;
      modelOe  = e.oe;
      lastByte = b;
    end
    for (int i = 0; i < 11; i++) begin
      if (i == rstBit) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
        modelRda = 1'b0;
        modelOe  = 1'b0;
      end
      for (int t = 0; t < 16; t++) begin
        RxD = (i == noiseBit && t == 8) ? ~bits[i] : bits[i];
        if (clrAtDone && i == 10 && t == 9) begin
          repeat (3) @(posedge clk);
          #1;
          clr_rda = 1'b1;
          tick();
          clr_rda = 1'b0;
        end else begin
          tick();
        end
      end
    end
    RxD = 1'b1;
  endtask

  task automatic clearRda();
    clr_rda = 1'b1;
    @(posedge clk);
    #1;
    clr_rda  = 1'b0;
    modelRda = 1'b0;
    modelOe  = 1'b0;
    check("rda_after_clr", RDA, 0);
    check("fe_after_clr", framing_err, 0);
    check("oe_after_clr", overrun_err, 0);
  endtask

  // Monitor: a new byte is any RDA rise or output change while RDA is held.
  initial begin
    forever begin
      @(negedge clk);
      if (RDA && (!prevRda || RxD_data != prevData || framing_err != prevFe ||
                  overrun_err != prevOe)) begin
        if (sb.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL unexpected_byte: actual 0x%0h, expected no delivery", RxD_data);
        end else begin
          got = sb.pop_front();
          check("rx_data", RxD_data, got.data);
          check("framing_err", framing_err, got.fe);
          check("overrun_err", overrun_err, got.oe);
          if (got.tick >= 0) check("completion_tick", tickCount, got.tick);
        end
      end
      prevRda  = RDA;
      prevData = RxD_data;
      prevFe   = framing_err;
      prevOe   = overrun_err;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_rda", RDA, 0);
    check("reset_data", RxD_data, 8'h00);
    check("reset_fe", framing_err, 0);
    check("reset_oe", overrun_err, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Clean frame with exact latency.
    sendFrame(8'hA5, 1'b1, 1'b1, -1, -1, 1'b1, 1'b1, 1'b0);
    repeat (4) tick();
    check("clean_rda", RDA, 1);
    clearRda();

    // Short glitch must be rejected as a false start.
    tick();
    RxD = 1'b0;
    repeat (4) tick();
    RxD = 1'b1;
    repeat (30) tick();
    check("glitch_rda", RDA, 0);
    sendFrame(8'h3C, 1'b1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    clearRda();

    // One-tick noise mid data bit 3 is outvoted.
    sendFrame(8'h00, 1'b1, 1'b1, 4, -1, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    clearRda();

    // Stop1 low: byte still delivered with framing error.
    sendFrame(8'h5A, 1'b0, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    check("fe_set", framing_err, 1);
    clearRda();

    // Back-to-back overrun, then again with clear on the completion cycle.
    sendFrame(8'h11, 1'b1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
    sendFrame(8'h22, 1'b1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
    sendFrame(8'h11, 1'b1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
    sendFrame(8'h22, 1'b1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b1);
    repeat (2) tick();
    check("clr_done_rda", RDA, 1);
    check("clr_done_oe", overrun_err, 0);
    clearRda();

    // Reset mid-frame aborts it; the next frame is intact.
    sendFrame(8'h00, 1'b1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
    sendFrame(8'hFF, 1'b1, 1'b1, -1, 5, 1'b0, 1'b0, 1'b0);
    check("rst_rda", RDA, 0);
    check("rst_data", RxD_data, 8'h00);
    check("rst_oe", overrun_err, 0);
    sendFrame(8'h81, 1'b1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    clearRda();

    // Randomized traffic with irregular baud ticks.
    enMode = 1;
    for (int n = 0; n < 24; n++) begin
      rb    = 8'($urandom);
      rs1   = ($urandom_range(0, 4) != 0);
      rs2   = ($urandom_range(0, 4) != 0);
      doClr = 1'($urandom_range(0, 1));
      if (rb == lastByte) rb = rb ^ 8'h01;
      sendFrame(rb, rs1, rs2, -1, -1, 1'b1, 1'b0, 1'b0);
      if (doClr) clearRda();
      // A low stop2 line looks like a start edge; let that false start expire.
      if (!rs2) repeat (20) tick();
      else repeat ($urandom_range(0, 10)) tick();
    end

    sendFrame(8'hC3, 1'b1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    modelRda = 1'b0;
    modelOe  = 1'b0;
    #1;
    check("final_rst_data", RxD_data, 8'h00);
    check("final_rst_rda", RDA, 0);
    repeat (10) tick();
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
